// File: rtl/countdown19bit_if.sv
// Load handshake, control and status bundle for the 19-bit down-counter.
// The slave modport is the counter's view; the master modport is the driver's.
interface countdown19bit_if #(
  parameter int WIDTH = 19
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             enable;
  logic             stop;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;

  modport slave (
    input  load_valid,
    input  load_value,
    input  auto_reload,
    input  enable,
    input  stop,
    output load_ready,
    output out,
    output tc,
    output busy
  );

  modport master (
    output load_valid,
    output load_value,
    output auto_reload,
    output enable,
    output stop,
    input  load_ready,
    input  out,
    input  tc,
    input  busy
  );
endinterface

// File: rtl/countdown19bit.sv
// Loadable 19-bit down-counter / interval timer.
// A non-zero start value is taken over a valid/ready handshake while IDLE; the
// count then decrements once per enabled clock. Reaching 1 on an enabled edge
// is the expiry: tc pulses for one cycle and the counter either returns to IDLE
// with out=0 (one-shot) or reloads the captured start value and keeps running
// (auto-reload). A zero load is an immediate expiry that never enters RUN.
module countdown19bit #(
  parameter int WIDTH = 19
) (
  input  logic                clk,
  input  logic                reset,   // synchronous, active-low
  countdown19bit_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state logic: load handling in IDLE, stop > enable-gate > count in RUN.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stop has no meaning in IDLE, so a simultaneous load still wins.
        if (bus.load_valid) begin
          if (bus.load_value != '0) begin
            out_d    = bus.load_value;
            reload_d = bus.load_value;
            mode_d   = bus.auto_reload;
            state_d  = RUN;
          end else begin
            out_d = '0;
            tc_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.enable) begin
          if (out_q > WIDTH'(1)) begin
            out_d = out_q - WIDTH'(1);
          end else begin
            // out is never below 1 while running, so this is the expiry edge.
            tc_d = 1'b1;
            if (mode_q) begin
              out_d = reload_q;
            end else begin
              out_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out        = out_q;
  assign bus.tc         = tc_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_countdown19bit.sv
// Directed bench for countdown19bit: an expiry-count model is compared against
// the DUT every cycle, and literal expectations pin each directed scenario.
module tb_countdown19bit;
  localparam int WIDTH = 19;

  logic clk;
  logic reset;

  countdown19bit_if #(.WIDTH(WIDTH)) bus ();

  countdown19bit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts enabled edges remaining until expiry.
  bit m_run;
  bit m_periodic;
  bit m_tc;
  int m_cnt;
  int m_period;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge from the sampled inputs, then compare shortly after.
  always @(posedge clk) begin
    if (!reset) begin
      m_run = 0; m_periodic = 0; m_tc = 0; m_cnt = 0; m_period = 0;
    end else begin
      m_tc = 0;
      if (!m_run) begin
        if (bus.load_valid) begin
          if (bus.load_value == 0) begin
            m_cnt = 0;
            m_tc  = 1;
          end else begin
            m_run      = 1;
            m_cnt      = int'(bus.load_value);
            m_period   = int'(bus.load_value);
            m_periodic = bus.auto_reload;
          end
        end
      end else if (bus.stop) begin
        m_run = 0;
      end else if (bus.enable) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_tc = 1;
          if (m_periodic) m_cnt = m_period;
          else            m_run = 0;
        end
      end
    end
    #1;
    check("model_out",   int'(bus.out),        m_cnt);
    check("model_tc",    int'(bus.tc),         int'(m_tc));
    check("model_busy",  int'(bus.busy),       int'(m_run));
    check("model_ready", int'(bus.load_ready), int'(!m_run));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.load_valid  = 1'b0;
    bus.load_value  = '0;
    bus.auto_reload = 1'b0;
    bus.enable      = 1'b0;
    bus.stop        = 1'b0;
  endtask

  task automatic do_load(input int value, input bit auto, input bit en);
    bus.load_valid  = 1'b1;
    bus.load_value  = WIDTH'(value);
    bus.auto_reload = auto;
    bus.enable      = en;
    tick();
    bus.load_valid  = 1'b0;
  endtask

  int ar_seq [12];
  bit en_seq [4];
  int en_out [4];
  int tc_count;

  initial begin
    total = 0;
    bad   = 0;
    ar_seq = '{3, 2, 1, 4, 3, 2, 1, 4, 3, 2, 1, 4};
    en_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    en_out = '{1, 1, 1, 0};

    // Reset held with random inputs.
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      bus.load_valid  = 1'($urandom);
      bus.load_value  = WIDTH'($urandom);
      bus.auto_reload = 1'($urandom);
      bus.enable      = 1'($urandom);
      bus.stop        = 1'($urandom);
      tick();
    end
    check("rst_out",   int'(bus.out), 0);
    check("rst_tc",    int'(bus.tc), 0);
    check("rst_busy",  int'(bus.busy), 0);
    check("rst_ready", int'(bus.load_ready), 1);
    do_load(5, 1'b0, 1'b1);
    check("rst_load_ignored", int'(bus.out), 0);
    check("rst_load_busy", int'(bus.busy), 0);
    reset = 1'b1;
    idle_inputs();
    tick();

    // One-shot: 3,2,1,0 with tc on the 0.
    do_load(3, 1'b0, 1'b1);
    check("os_out3", int'(bus.out), 3);
    check("os_busy", int'(bus.busy), 1);
    tick(); check("os_out2", int'(bus.out), 2);
    tick(); check("os_out1", int'(bus.out), 1);
    check("os_tc_pre", int'(bus.tc), 0);
    tick();
    check("os_out0", int'(bus.out), 0);
    check("os_tc", int'(bus.tc), 1);
    check("os_busy_end", int'(bus.busy), 0);
    check("os_ready_end", int'(bus.load_ready), 1);
    tick(); check("os_tc_single", int'(bus.tc), 0);

    // Auto-reload with period 4.
    do_load(4, 1'b1, 1'b1);
    check("ar_out4", int'(bus.out), 4);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("ar_out_%0d", i), int'(bus.out), ar_seq[i]);
      check($sformatf("ar_tc_%0d", i), int'(bus.tc), ((i % 4) == 3) ? 1 : 0);
      check($sformatf("ar_busy_%0d", i), int'(bus.busy), 1);
    end
    bus.stop = 1'b1;
    tick();
    check("ar_stop_busy", int'(bus.busy), 0);
    check("ar_stop_out", int'(bus.out), 4);
    idle_inputs();

    // Enable gating: 2 then 1,1,1,0 for enable 1,0,0,1.
    do_load(2, 1'b0, 1'b1);
    check("eg_out2", int'(bus.out), 2);
    tc_count = 0;
    for (int i = 0; i < 4; i++) begin
      bus.enable = en_seq[i];
      tick();
      check($sformatf("eg_out_%0d", i), int'(bus.out), en_out[i]);
      tc_count += int'(bus.tc);
    end
    tick();
    tc_count += int'(bus.tc);
    check("eg_tc_count", tc_count, 1);

    // Maximum load value.
    do_load(524287, 1'b0, 1'b1);
    check("max_load", int'(bus.out), 524287);
    tick();
    check("max_dec", int'(bus.out), 524286);
    bus.stop = 1'b1;
    tick();
    idle_inputs();

    // Load ignored in RUN, then stop on the cycle out==1.
    do_load(2, 1'b0, 1'b1);
    bus.load_valid = 1'b1;
    bus.load_value = WIDTH'(9);
    tick();
    check("run_load_ignored", int'(bus.out), 1);
    bus.load_valid = 1'b0;
    bus.stop = 1'b1;
    tick();
    check("stop_out", int'(bus.out), 1);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_tc", int'(bus.tc), 0);
    bus.stop = 1'b0;
    tick();
    check("stop_tc_after", int'(bus.tc), 0);

    // Load together with stop in IDLE: load wins.
    bus.stop = 1'b1;
    do_load(6, 1'b0, 1'b0);
    check("ls_out", int'(bus.out), 6);
    check("ls_busy", int'(bus.busy), 1);
    tick();
    check("ls_stopped", int'(bus.busy), 0);
    idle_inputs();

    // Zero load: immediate tc, stays IDLE.
    do_load(0, 1'b0, 1'b1);
    check("zl_tc", int'(bus.tc), 1);
    check("zl_busy", int'(bus.busy), 0);
    check("zl_out", int'(bus.out), 0);
    tick();
    check("zl_tc_single", int'(bus.tc), 0);

    // Load accepted on the one-shot expiry edge's following cycle.
    do_load(1, 1'b0, 1'b1);
    tick();
    check("bb_tc", int'(bus.tc), 1);
    check("bb_ready", int'(bus.load_ready), 1);
    do_load(2, 1'b0, 1'b0);
    check("bb_reload_out", int'(bus.out), 2);
    check("bb_reload_busy", int'(bus.busy), 1);
    bus.stop = 1'b1;
    tick();
    idle_inputs();

    // Mid-run reset.
    do_load(100, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check("mr_out_pre", int'(bus.out), 90);
    reset = 1'b0;
    tick();
    check("mr_out", int'(bus.out), 0);
    check("mr_busy", int'(bus.busy), 0);
    check("mr_tc", int'(bus.tc), 0);
    reset = 1'b1;
    bus.enable = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
